// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Chooses, every cycle, whether ID passes its instruction to ID/EXE, inserts a
// bubble or freezes. It also gates the PC and IF/ID writes. It covers load-use
// stalls, EXE-resolved redirects (multi-cycle flush window) and data-memory
// freezes.
// Optional build macro HAZARD_PERF_CNT_EN: when defined, the three 16-bit
// saturating event counters are built. When undefined, the counter outputs
// are tied to zero.
module hazard_ctrl #(
    parameter int ASIZE        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] id_raddr1,
    input  logic [ASIZE-1:0] id_raddr2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             ex_wen,
    input  logic             ex_mem_read,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic [15:0]      lu_stall_cnt,
    output logic [15:0]      flush_cnt,
    output logic [15:0]      mem_stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic       lu;
    logic       freeze_cyc;   // memory-freeze cycle
    logic       flush_cyc;    // flushed cycle
    logic       stall_cyc;    // load-use stall cycle

    // Load-use hazard against the load sitting in EXE; r0 never hazards
    assign lu = ex_mem_read & ex_wen & (ex_waddr != '0) &
                ((id_use1 & (id_raddr1 == ex_waddr)) |
                 (id_use2 & (id_raddr2 == ex_waddr)));

    // State and flush-window counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Prioritised output decode and next-state logic
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_wen      = 1'b1;
        ifid_wen    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        freeze_cyc  = 1'b0;
        flush_cyc   = 1'b0;
        stall_cyc   = 1'b0;
        if (rst) begin
            // Fill the front of the pipe with NOPs while in reset
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            // Whole pipe frozen; the flush window is paused too
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_hold  = 1'b1;
            freeze_cyc = 1'b1;
        end else if (state_q == FLUSH || ex_redirect) begin
            // Squash wrong-path instructions; load-use is irrelevant here
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_cyc   = 1'b1;
            if (state_q == RUN) begin
                if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_INIT;
                end
            end else if (fcnt_q > 4'd1) begin
                fcnt_d = fcnt_q - 4'd1;
            end else begin
                state_d = RUN;
                fcnt_d  = 4'd0;
            end
        end else if (lu) begin
            // One-cycle stall; the bubble drops lu on the next cycle
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            idex_bubble = 1'b1;
            stall_cyc   = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] lu_cnt_q, flush_cnt_q, mem_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_q    <= 16'h0;
            flush_cnt_q <= 16'h0;
            mem_cnt_q   <= 16'h0;
        end else begin
            if (stall_cyc && lu_cnt_q != 16'hFFFF)
                lu_cnt_q <= lu_cnt_q + 16'h1;
            if (flush_cyc && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'h1;
            if (freeze_cyc && mem_cnt_q != 16'hFFFF)
                mem_cnt_q <= mem_cnt_q + 16'h1;
        end
    end

    assign lu_stall_cnt  = lu_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign mem_stall_cnt = mem_cnt_q;
`else
    logic unused_evt;
    assign unused_evt    = stall_cyc ^ flush_cyc ^ freeze_cyc;
    assign lu_stall_cnt  = 16'h0;
    assign flush_cnt     = 16'h0;
    assign mem_stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (FLUSH_CYCLES = 2).
// The control vector is {pc_wen, ifid_wen, ifid_flush, idex_bubble, idex_hold}.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [4:0] C_PASS   = 5'b11000;
    localparam logic [4:0] C_FLUSH  = 5'b11110;
    localparam logic [4:0] C_STALL  = 5'b00010;
    localparam logic [4:0] C_FREEZE = 5'b00001;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_raddr1, id_raddr2, ex_waddr;
    logic       id_use1, id_use2, ex_wen, ex_mem_read, ex_redirect, mem_busy;
    logic       pc_wen, ifid_wen, ifid_flush, idex_bubble, idex_hold;
    logic [15:0] lu_stall_cnt, flush_cnt, mem_stall_cnt;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_lu, exp_fl, exp_mem;
    logic [4:0]  got;

    hazard_ctrl #(.ASIZE(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .id_use1(id_use1), .id_use2(id_use2),
        .ex_wen(ex_wen), .ex_mem_read(ex_mem_read), .ex_waddr(ex_waddr),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_hold(idex_hold),
        .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt),
        .mem_stall_cnt(mem_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ctl();
        return {pc_wen, ifid_wen, ifid_flush, idex_bubble, idex_hold};
    endfunction

    // Advance to the next negedge (inputs are driven here), then settle
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        id_raddr1 = 4'd0; id_raddr2 = 4'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        ex_wen = 1'b0; ex_mem_read = 1'b0; ex_waddr = 4'd0;
        ex_redirect = 1'b0; mem_busy = 1'b0;
    endtask

    // Present a load in EXE writing r3 and an ID instruction reading r3 on port 2
    task automatic set_lu();
        ex_mem_read = 1'b1; ex_wen = 1'b1; ex_waddr = 4'd3;
        id_use2 = 1'b1; id_raddr2 = 4'd3;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        step(); #1;
        got = ctl(); checks++;
        if (got !== C_FLUSH) begin failures++;
            $display("FAIL reset_ctl got=%b exp=%b", got, C_FLUSH); end
        step(); #1;
        checks++;
        if ({lu_stall_cnt, flush_cnt, mem_stall_cnt} !== 48'h0) begin failures++;
            $display("FAIL reset_cnt got=%h/%h/%h exp=0", lu_stall_cnt, flush_cnt, mem_stall_cnt); end
        rst = 1'b0;
        #1; got = ctl(); checks++;
        if (got !== C_PASS) begin failures++;
            $display("FAIL reset_release_ctl got=%b exp=%b", got, C_PASS); end
        exp_lu = 0; exp_fl = 0; exp_mem = 0;
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        step(); set_lu(); #1;
        got = ctl(); checks++;
        if (got !== C_STALL) begin failures++;
            $display("FAIL lu_raddr2_ctl got=%b exp=%b", got, C_STALL); end
        if (CNT_EN) exp_lu = exp_lu + 1;
        step(); idle(); #1;
        got = ctl(); checks++;
        if (got !== C_PASS) begin failures++;
            $display("FAIL lu_after_ctl got=%b exp=%b", got, C_PASS); end
        checks++;
        if (lu_stall_cnt !== exp_lu) begin failures++;
            $display("FAIL lu_cnt got=%0d exp=%0d", lu_stall_cnt, exp_lu); end
        // Same hazard through source port 1
        step(); ex_mem_read = 1'b1; ex_wen = 1'b1; ex_waddr = 4'd9;
        id_use1 = 1'b1; id_raddr1 = 4'd9; #1;
        got = ctl(); checks++;
        if (got !== C_STALL) begin failures++;
            $display("FAIL lu_raddr1_ctl got=%b exp=%b", got, C_STALL); end
        if (CNT_EN) exp_lu = exp_lu + 1;
        step(); idle(); #1;
        checks++;
        if (lu_stall_cnt !== exp_lu) begin failures++;
            $display("FAIL lu_cnt2 got=%0d exp=%0d", lu_stall_cnt, exp_lu); end
        $display("test_load_use done");
    endtask

    task automatic test_no_stall();
        // r0 destination never hazards
        step(); ex_mem_read = 1'b1; ex_wen = 1'b1; ex_waddr = 4'd0;
        id_use1 = 1'b1; id_raddr1 = 4'd0; #1;
        got = ctl(); checks++;
        if (got !== C_PASS) begin failures++;
            $display("FAIL r0_ctl got=%b exp=%b", got, C_PASS); end
        // Matching register but source not used
        step(); ex_waddr = 4'd5; id_raddr1 = 4'd5; id_use1 = 1'b0; #1;
        got = ctl(); checks++;
        if (got !== C_PASS) begin failures++;
            $display("FAIL unused_src_ctl got=%b exp=%b", got, C_PASS); end
        // Load that does not write a register
        step(); id_use1 = 1'b1; ex_wen = 1'b0; #1;
        got = ctl(); checks++;
        if (got !== C_PASS) begin failures++;
            $display("FAIL no_wen_ctl got=%b exp=%b", got, C_PASS); end
        // Non-load producer: forwarding covers it
        step(); ex_wen = 1'b1; ex_mem_read = 1'b0; #1;
        got = ctl(); checks++;
        if (got !== C_PASS) begin failures++;
            $display("FAIL no_load_ctl got=%b exp=%b", got, C_PASS); end
        step(); idle();
        $display("test_no_stall done");
    endtask

    task automatic test_redirect();
        step(); ex_redirect = 1'b1; #1;
        got = ctl(); checks++;
        if (got !== C_FLUSH) begin failures++;
            $display("FAIL redir_c1 got=%b exp=%b", got, C_FLUSH); end
        step(); ex_redirect = 1'b0; #1;
        got = ctl(); checks++;
        if (got !== C_FLUSH) begin failures++;
            $display("FAIL redir_c2 got=%b exp=%b", got, C_FLUSH); end
        step(); #1;
        got = ctl(); checks++;
        if (got !== C_PASS) begin failures++;
            $display("FAIL redir_end got=%b exp=%b", got, C_PASS); end
        if (CNT_EN) exp_fl = exp_fl + 2;
        checks++;
        if (flush_cnt !== exp_fl) begin failures++;
            $display("FAIL flush_cnt got=%0d exp=%0d", flush_cnt, exp_fl); end
        $display("test_redirect done");
    endtask

    task automatic test_priority();
        step(); ex_redirect = 1'b1; set_lu(); #1;
        got = ctl(); checks++;
        if (got !== C_FLUSH) begin failures++;
            $display("FAIL prio_redir_lu got=%b exp=%b", got, C_FLUSH); end
        step(); ex_redirect = 1'b0; #1;
        got = ctl(); checks++;
        if (got !== C_FLUSH) begin failures++;
            $display("FAIL prio_flush_lu got=%b exp=%b", got, C_FLUSH); end
        if (CNT_EN) exp_fl = exp_fl + 2;
        step(); idle(); #1;
        checks++;
        if (lu_stall_cnt !== exp_lu || flush_cnt !== exp_fl) begin failures++;
            $display("FAIL prio_cnt got=%0d/%0d exp=%0d/%0d", lu_stall_cnt, flush_cnt, exp_lu, exp_fl); end
        // Freeze outranks load-use
        step(); set_lu(); mem_busy = 1'b1; #1;
        got = ctl(); checks++;
        if (got !== C_FREEZE) begin failures++;
            $display("FAIL prio_busy_lu got=%b exp=%b", got, C_FREEZE); end
        if (CNT_EN) exp_mem = exp_mem + 1;
        step(); idle();
        $display("test_priority done");
    endtask

    task automatic test_redirect_in_flush();
        // A second redirect during FLUSH must not extend the window
        step(); ex_redirect = 1'b1;
        step(); #1;
        got = ctl(); checks++;
        if (got !== C_FLUSH) begin failures++;
            $display("FAIL rif_c2 got=%b exp=%b", got, C_FLUSH); end
        step(); ex_redirect = 1'b0; #1;
        got = ctl(); checks++;
        if (got !== C_PASS) begin failures++;
            $display("FAIL rif_end got=%b exp=%b", got, C_PASS); end
        if (CNT_EN) exp_fl = exp_fl + 2;
        $display("test_redirect_in_flush done");
    endtask

    task automatic test_busy_flush();
        step(); ex_redirect = 1'b1;
        step(); ex_redirect = 1'b0; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #1; got = ctl(); checks++;
            if (got !== C_FREEZE) begin failures++;
                $display("FAIL busy_freeze[%0d] got=%b exp=%b", i, got, C_FREEZE); end
        end
        step(); mem_busy = 1'b0; #1;
        got = ctl(); checks++;
        if (got !== C_FLUSH) begin failures++;
            $display("FAIL busy_resume got=%b exp=%b", got, C_FLUSH); end
        step(); #1;
        got = ctl(); checks++;
        if (got !== C_PASS) begin failures++;
            $display("FAIL busy_end got=%b exp=%b", got, C_PASS); end
        if (CNT_EN) begin exp_fl = exp_fl + 2; exp_mem = exp_mem + 3; end
        checks++;
        if (mem_stall_cnt !== exp_mem || flush_cnt !== exp_fl) begin failures++;
            $display("FAIL busy_cnt got=%0d/%0d exp=%0d/%0d", mem_stall_cnt, flush_cnt, exp_mem, exp_fl); end
        $display("test_busy_flush done");
    endtask

    task automatic test_reset_mid_flush();
        step(); ex_redirect = 1'b1;
        step(); ex_redirect = 1'b0; rst = 1'b1; mem_busy = 1'b1; #1;
        got = ctl(); checks++;
        if (got !== C_FLUSH) begin failures++;
            $display("FAIL rst_force got=%b exp=%b", got, C_FLUSH); end
        step(); rst = 1'b0; mem_busy = 1'b0; #1;
        got = ctl(); checks++;
        if (got !== C_PASS) begin failures++;
            $display("FAIL rst_run got=%b exp=%b", got, C_PASS); end
        checks++;
        if ({lu_stall_cnt, flush_cnt, mem_stall_cnt} !== 48'h0) begin failures++;
            $display("FAIL rst_cnt got=%h/%h/%h exp=0", lu_stall_cnt, flush_cnt, mem_stall_cnt); end
        $display("test_reset_mid_flush done");
    endtask

    initial begin
        rst = 1'b1; idle();
        exp_lu = 0; exp_fl = 0; exp_mem = 0;
        test_reset();
        test_load_use();
        test_no_stall();
        test_redirect();
        test_priority();
        test_redirect_in_flush();
        test_busy_flush();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
